// File: rtl/block_ram_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port BlockRam between the host port and the core port.
// Latency: request to RAM is combinational; read data returns exactly RAM_LATENCY cycles after acceptance.
// Backpressure: X_ready grants at most one requester per cycle; the loser holds its request for one cycle.
module block_ram_arbiter #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int RAM_LATENCY   = 1
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     host_req,
    input  logic                     host_write,
    input  logic [ADDRESS_WIDTH-1:0] host_address,
    input  logic [WORD_WIDTH-1:0]    host_in_data,
    output logic                     host_ready,
    output logic [WORD_WIDTH-1:0]    host_out_data,
    output logic                     host_out_valid,

    input  logic                     core_req,
    input  logic                     core_write,
    input  logic [ADDRESS_WIDTH-1:0] core_address,
    input  logic [WORD_WIDTH-1:0]    core_in_data,
    output logic                     core_ready,
    output logic [WORD_WIDTH-1:0]    core_out_data,
    output logic                     core_out_valid,

    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_write,
    output logic [WORD_WIDTH-1:0]    ram_in_data,
    input  logic [WORD_WIDTH-1:0]    ram_out_data
);

    // 1 when the core received the most recent grant; reset value makes the host win the first conflict
    logic last_grant_core;
    logic host_grant;
    logic core_grant;
    logic read_accept;

    // Tag pipeline: one entry per cycle of RAM latency, tracking whether a read is in flight and for whom
    logic [RAM_LATENCY-1:0] tag_valid;
    logic [RAM_LATENCY-1:0] tag_core;

    // Grant: a lone requester always wins; on conflict the requester that did not win last time goes
    always_comb begin
        host_grant = 1'b0;
        core_grant = 1'b0;
        if (!reset) begin
            if (host_req && core_req) begin
                host_grant = last_grant_core;
                core_grant = !last_grant_core;
            end else begin
                host_grant = host_req;
                core_grant = core_req;
            end
        end
    end

    assign host_ready  = host_grant;
    assign core_ready  = core_grant;
    assign read_accept = (host_grant && !host_write) || (core_grant && !core_write);

    // RAM drive: granted requester's fields; host fields when idle with the write suppressed
    always_comb begin
        ram_address = host_address;
        ram_in_data = host_in_data;
        ram_write   = 1'b0;
        if (core_grant) begin
            ram_address = core_address;
            ram_in_data = core_in_data;
            ram_write   = core_write;
        end else if (host_grant) begin
            ram_write   = host_write;
        end
    end

    // Remember who won the last transfer; hold through idle cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_core <= 1'b1;
        end else if (host_grant) begin
            last_grant_core <= 1'b0;
        end else if (core_grant) begin
            last_grant_core <= 1'b1;
        end
    end

    // Shift read tags alongside the RAM's internal latency; reset drops anything in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid <= '0;
            tag_core  <= '0;
        end else begin
            tag_valid[0] <= read_accept;
            tag_core[0]  <= core_grant;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_core[i]  <= tag_core[i-1];
            end
        end
    end

    // Read data is the RAM output for both ports; the tag at pipeline exit decides who sees a valid pulse
    assign host_out_data  = ram_out_data;
    assign core_out_data  = ram_out_data;
    assign host_out_valid = !reset && tag_valid[RAM_LATENCY-1] && !tag_core[RAM_LATENCY-1];
    assign core_out_valid = !reset && tag_valid[RAM_LATENCY-1] &&  tag_core[RAM_LATENCY-1];

endmodule

// File: tb/tb_block_ram_arbiter.sv
module tb_block_ram_arbiter;

    localparam int WW  = 32;
    localparam int AW  = 16;
    localparam int LAT = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          host_req = 1'b0;
    logic          host_write = 1'b0;
    logic [AW-1:0] host_address = '0;
    logic [WW-1:0] host_in_data = '0;
    logic          host_ready;
    logic [WW-1:0] host_out_data;
    logic          host_out_valid;
    logic          core_req = 1'b0;
    logic          core_write = 1'b0;
    logic [AW-1:0] core_address = '0;
    logic [WW-1:0] core_in_data = '0;
    logic          core_ready;
    logic [WW-1:0] core_out_data;
    logic          core_out_valid;
    logic [AW-1:0] ram_address;
    logic          ram_write;
    logic [WW-1:0] ram_in_data;
    logic [WW-1:0] ram_out_data;

    always #5 clock = ~clock;

    block_ram_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .RAM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .host_req(host_req), .host_write(host_write), .host_address(host_address),
        .host_in_data(host_in_data), .host_ready(host_ready),
        .host_out_data(host_out_data), .host_out_valid(host_out_valid),
        .core_req(core_req), .core_write(core_write), .core_address(core_address),
        .core_in_data(core_in_data), .core_ready(core_ready),
        .core_out_data(core_out_data), .core_out_valid(core_out_valid),
        .ram_address(ram_address), .ram_write(ram_write),
        .ram_in_data(ram_in_data), .ram_out_data(ram_out_data)
    );

    // Write-first single-port BlockRam with LAT cycles of read latency
    logic [WW-1:0] mem [0:(1<<AW)-1];
    logic [WW-1:0] ram_pipe [LAT];
    assign ram_out_data = ram_pipe[LAT-1];
    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        for (int i = 0; i < LAT; i++) ram_pipe[i] = '0;
        forever begin
            @(posedge clock);
            if (ram_write) mem[ram_address] <= ram_in_data;
            ram_pipe[0] <= ram_write ? ram_in_data : mem[ram_address];
            for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
        end
    end

    typedef struct { bit idle; bit wr; logic [AW-1:0] addr; logic [WW-1:0] data; } op_t;
    typedef struct { logic [WW-1:0] data; int due; } exp_t;

    op_t  cmdq_h[$];
    op_t  cmdq_c[$];
    exp_t exp_h[$];
    exp_t exp_c[$];
    logic [WW-1:0] shadow [0:(1<<AW)-1];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic op_t rd_op(input logic [AW-1:0] a);
        op_t o; o.idle = 0; o.wr = 0; o.addr = a; o.data = '0; return o;
    endfunction
    function automatic op_t wr_op(input logic [AW-1:0] a, input logic [WW-1:0] d);
        op_t o; o.idle = 0; o.wr = 1; o.addr = a; o.data = d; return o;
    endfunction
    function automatic op_t idle_op();
        op_t o; o.idle = 1; o.wr = 0; o.addr = '0; o.data = '0; return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Requester driver: present the next queued op once the current one is accepted
    initial begin
        op_t op;
        bit acc_h, acc_c;
        forever begin
            @(negedge clock);
            acc_h = host_req && host_ready;
            acc_c = core_req && core_ready;
            @(posedge clock); #1;
            if (acc_h || !host_req) begin
                if (cmdq_h.size() > 0) begin
                    op = cmdq_h.pop_front();
                    host_req = !op.idle; host_write = op.wr;
                    host_address = op.addr; host_in_data = op.data;
                end else host_req = 1'b0;
            end
            if (acc_c || !core_req) begin
                if (cmdq_c.size() > 0) begin
                    op = cmdq_c.pop_front();
                    core_req = !op.idle; core_write = op.wr;
                    core_address = op.addr; core_in_data = op.data;
                end else core_req = 1'b0;
            end
        end
    end

    // Reference model: decide the winner from the round-robin rule, track memory contents,
    // and queue the data each accepted read must return LAT cycles later
    initial begin
        bit last_core;
        bit gh, gc;
        logic [AW-1:0] a;
        exp_t e;
        for (int i = 0; i < (1<<AW); i++) shadow[i] = '0;
        last_core = 1'b1;
        forever begin
            @(negedge clock);
            if (reset) begin
                check("reset_host_ready", host_ready, 0);
                check("reset_core_ready", core_ready, 0);
                check("reset_ram_write", ram_write, 0);
                exp_h.delete();
                exp_c.delete();
                last_core = 1'b1;
            end else begin
                if (host_req && core_req) begin
                    gh = last_core;      // host's turn if core went last
                    gc = !last_core;
                end else begin
                    gh = host_req;
                    gc = core_req;
                end
                check("host_ready", host_ready, gh);
                check("core_ready", core_ready, gc);
                if (gh || gc) begin
                    a = gc ? core_address : host_address;
                    check("ram_address", ram_address, a);
                    check("ram_write", ram_write, gc ? core_write : host_write);
                    if (gc ? core_write : host_write) begin
                        check("ram_in_data", ram_in_data, gc ? core_in_data : host_in_data);
                        shadow[a] = gc ? core_in_data : host_in_data;
                    end else begin
                        e.data = shadow[a];
                        e.due  = cyc + LAT;
                        if (gc) exp_c.push_back(e); else exp_h.push_back(e);
                    end
                    last_core = gc;
                end else begin
                    check("idle_ram_write", ram_write, 0);
                    check("idle_ram_address", ram_address, host_address);
                end
            end
        end
    end

    // Scoreboard monitor: every out_valid pulse must match the oldest expected response for that port
    task automatic monitor_port(input bit is_core, input logic v, input logic [WW-1:0] d);
        exp_t e;
        int sz;
        sz = is_core ? exp_c.size() : exp_h.size();
        if (v) begin
            if (sz == 0) begin
                check(is_core ? "core_out_valid_unexpected" : "host_out_valid_unexpected", v, 0);
            end else begin
                e = is_core ? exp_c.pop_front() : exp_h.pop_front();
                check(is_core ? "core_out_data" : "host_out_data", d, e.data);
                check(is_core ? "core_return_cycle" : "host_return_cycle", cyc, e.due);
            end
        end else if (sz > 0) begin
            e = is_core ? exp_c[0] : exp_h[0];
            if (e.due <= cyc) begin
                e = is_core ? exp_c.pop_front() : exp_h.pop_front();
                check(is_core ? "core_out_valid_missing" : "host_out_valid_missing", v, 1);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock); #1;
            if (reset) begin
                check("reset_host_out_valid", host_out_valid, 0);
                check("reset_core_out_valid", core_out_valid, 0);
            end else begin
                monitor_port(1'b0, host_out_valid, host_out_data);
                monitor_port(1'b1, core_out_valid, core_out_data);
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((cmdq_h.size() > 0 || cmdq_c.size() > 0 || host_req || core_req ||
                exp_h.size() > 0 || exp_c.size() > 0) && n < 3000) begin
            @(negedge clock); #2;
            n++;
        end
        if (n >= 3000) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock); #2;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock); #2;

        // Host write then read back, core silent
        cmdq_h.push_back(wr_op(16'h0010, 32'hDEADBEEF));
        cmdq_h.push_back(rd_op(16'h0010));
        drain("t1");

        // Preload, then both ports reading together from reset: alternating grants, host first
        for (int i = 0; i < 6; i++) cmdq_h.push_back(wr_op(16'h0020 + 16'(i), $urandom));
        drain("t2_preload");
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cmdq_h.push_back(rd_op(16'h0020 + 16'(2*i)));
            cmdq_c.push_back(rd_op(16'h0021 + 16'(2*i)));
        end
        drain("t2");

        // Conflict after reset: host read sees old data, core write lands next, reread sees new data
        do_reset();
        cmdq_c.push_back(wr_op(16'h0004, 32'h12345678));
        cmdq_h.push_back(rd_op(16'h0004));
        cmdq_h.push_back(rd_op(16'h0004));
        drain("t3");

        // Host-only streaming reads with no bubbles
        for (int i = 0; i < 8; i++) cmdq_h.push_back(wr_op(AW'(i), WW'(i*3)));
        drain("t4_preload");
        for (int i = 0; i < 8; i++) cmdq_h.push_back(rd_op(AW'(i)));
        n = 0;
        while (!host_out_valid && n < 20) begin @(negedge clock); #2; n++; end
        for (int i = 0; i < 8; i++) begin
            check("t4_stream_valid", host_out_valid, 1);
            @(negedge clock); #2;
        end
        check("t4_stream_end", host_out_valid, 0);
        drain("t4");

        // Core read in flight when reset hits; requests held through reset; host wins after
        cmdq_c.push_back(rd_op(16'h0010));
        cmdq_c.push_back(wr_op(16'h0030, 32'hA5A5A5A5));
        n = 0;
        while (!(core_req && core_ready) && n < 20) begin @(negedge clock); n++; end
        if (n >= 20) begin
            n_cmp++; n_fail++;
            $display("FAIL t5_core_accept: not accepted in %0d cycles, required acceptance", n);
        end
        cmdq_h.push_back(rd_op(16'h0030));
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        drain("t5");

        // Idle: the model checks ready, ram_write and out_valid stay low
        repeat (10) @(negedge clock);

        // Random traffic on a small address window to provoke write/read hazards
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) cmdq_h.push_back(idle_op());
            else if ($urandom_range(0, 1) == 1) cmdq_h.push_back(wr_op(16'h0040 + 16'($urandom_range(0, 15)), $urandom));
            else cmdq_h.push_back(rd_op(16'h0040 + 16'($urandom_range(0, 15))));
            if ($urandom_range(0, 3) == 0) cmdq_c.push_back(idle_op());
            else if ($urandom_range(0, 1) == 1) cmdq_c.push_back(wr_op(16'h0040 + 16'($urandom_range(0, 15)), $urandom));
            else cmdq_c.push_back(rd_op(16'h0040 + 16'($urandom_range(0, 15))));
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
